// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus fetch/load-store arbiter.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_BUS,
    S_ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Avalon-MM master bus shared by fetch and load/store; master = arbiter side.
interface mips_cpu_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   address;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_cpu_bus_arbiter_pick.sv
// Combinational grant between fetch and load/store requests.
// MIPS_BUS_ARB_RR_EN: ties go to the port that did not own the previous transfer.
module mips_cpu_arb_pick
  import mips_cpu_bus_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t owner
);

  always_comb begin
    owner = last_owner;
    if (i_req && d_req) begin
`ifdef MIPS_BUS_ARB_RR_EN
      owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
      owner = OWN_D;
`endif
    end else if (d_req) begin
      owner = OWN_D;
    end else if (i_req) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares the Avalon-MM master of mips_cpu_bus between fetch (I) and load/store (D).
// Tie-break policy selected by MIPS_BUS_ARB_RR_EN (round-robin) in mips_cpu_arb_pick.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req,
  input  logic [AW-1:0]          i_addr,
  output logic                   i_done,
  output logic [DW-1:0]          i_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [AW-1:0]          d_addr,
  input  logic [DW-1:0]          d_wdata,
  input  logic [DW/8-1:0]        d_be,
  output logic                   d_done,
  output logic [DW-1:0]          d_rdata,
  mips_cpu_bus_arbiter_if.master bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       stall_cnt
);

  arb_state_t      state_q, state_d;
  arb_owner_t      owner_q, owner_d, grant;
  logic            read_q, read_d, write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] be_q, be_d;
  logic            i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic            i_req_m, d_req_m;

  // A port whose done is showing is still holding req; ignore it for one cycle.
  assign i_req_m = i_req & ~i_done_q;
  assign d_req_m = d_req & ~d_done_q;

  mips_cpu_arb_pick u_pick (
    .i_req      (i_req_m),
    .d_req      (d_req_m),
    .last_owner (owner_q),
    .owner      (grant)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    read_d    = read_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    stall_d   = stall_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    case (state_q)
      S_ARB_IDLE: begin
        if (i_req_m || d_req_m) begin
          owner_d = grant;
          state_d = S_ARB_BUS;
          if (grant == OWN_D) begin
            addr_d  = d_addr & ~AW'(3);
            wdata_d = d_wdata;
            be_d    = d_be;
            read_d  = ~d_we;
            write_d = d_we;
          end else begin
            addr_d  = i_addr & ~AW'(3);
            be_d    = {(DW/32){BE_FULL}};
            read_d  = 1'b1;
            write_d = 1'b0;
          end
        end
      end
      S_ARB_BUS: begin
        if (bus.waitrequest) begin
          if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            state_d = S_ARB_RESP;
          end else begin
            state_d  = S_ARB_IDLE;
            d_done_d = 1'b1;
          end
        end
      end
      S_ARB_RESP: begin
        state_d = S_ARB_IDLE;
        if (owner_q == OWN_D) begin
          d_rdata_d = bus.readdata;
          d_done_d  = 1'b1;
        end else begin
          i_rdata_d = bus.readdata;
          i_done_d  = 1'b1;
        end
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_ARB_IDLE;
      owner_q   <= OWN_I;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;
  assign i_done         = i_done_q;
  assign d_done         = d_done_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign stall_cnt      = stall_q;
  assign busy           = (state_q != S_ARB_IDLE);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed latency/priority/reset/saturation cases
// followed by randomized traffic checked against a transaction-level model.
module tb_mips_cpu_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CNT_W = 16;
`ifdef MIPS_BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             i_req = 1'b0;
  logic [AW-1:0]    i_addr = '0;
  logic             i_done;
  logic [DW-1:0]    i_rdata;
  logic             d_req = 1'b0;
  logic             d_we = 1'b0;
  logic [AW-1:0]    d_addr = '0;
  logic [DW-1:0]    d_wdata = '0;
  logic [3:0]       d_be = '0;
  logic             d_done;
  logic [DW-1:0]    d_rdata;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  mips_cpu_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips_cpu_bus_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .bus       (bus),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a ^ 32'hA5A5_1234) * 32'h0001_0003 + 32'h11;
  endfunction

  // per-cycle snapshots for the directed cases
  logic        rd_a [0:15];
  logic        wr_a [0:15];
  logic        id_a [0:15];
  logic        dd_a [0:15];
  logic [31:0] ad_a [0:15];
  logic [31:0] ir_a [0:15];
  logic [31:0] dr_a [0:15];
  logic [31:0] wd_a [0:15];
  logic [3:0]  be_a [0:15];
  logic [15:0] st_a [0:15];

  task automatic samp(input int k);
    rd_a[k] = bus.read;     wr_a[k] = bus.write;
    id_a[k] = i_done;       dd_a[k] = d_done;
    ad_a[k] = bus.address;  ir_a[k] = i_rdata;
    dr_a[k] = d_rdata;      wd_a[k] = bus.writedata;
    be_a[k] = bus.byteenable; st_a[k] = stall_cnt;
  endtask

  // random-phase model state
  int          exp_i_at, exp_d_at, resp_at;
  bit          pend_i, pend_d, drop_i, drop_d, elig_i, elig_d, prev_bus;
  bit          own_d_m, last_d_m, txn_rd, rd, wr, id, dd;
  int unsigned stall_left, age_i, age_d;
  logic [31:0] txn_addr, ir_m, dr_m;
  logic [15:0] st_m;

  initial begin
    logic [31:0] fa, sa;
    bit first_is_d, any_done, any_bus;
    int dcyc;

    bus.waitrequest = 1'b0;
    bus.readdata    = '0;

    // ---------------- reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_read", bus.read, 0);
    check("rst_write", bus.write, 0);
    check("rst_done", {i_done, d_done}, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", bus.address, 0);
    check("rst_wdata", bus.writedata, 0);
    check("rst_be", bus.byteenable, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_stall", stall_cnt, 0);
    reset = 1'b1;

    // ---------------- I read, zero wait
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hBFC0_0000; bus.readdata = 32'h2402_0005;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      samp(k);
      if (k == 4) i_req = 1'b0;
    end
    check("t1_read_c1", rd_a[1], 1);
    check("t1_addr", ad_a[1], 32'hBFC0_0000);
    check("t1_be", be_a[1], 4'hF);
    check("t1_busy_c1", 1'b1, 1'b1 & rd_a[1]);
    check("t1_read_c2", rd_a[2], 0);
    check("t1_idone_c2", id_a[2], 0);
    check("t1_idone_c3", id_a[3], 1);
    check("t1_irdata", ir_a[3], 32'h2402_0005);
    check("t1_nodouble", rd_a[4], 0);
    check("t1_idone_c4", id_a[4], 0);
    check("t1_ddone", dd_a[3], 0);

    // ---------------- D write, two wait states, unaligned address
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1003; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    bus.waitrequest = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      samp(k);
      if (k == 3) bus.waitrequest = 1'b0;
      if (k == 5) d_req = 1'b0;
    end
    check("t2_addr", ad_a[1], 32'h0000_1000);
    check("t2_wdata", wd_a[1], 32'hDEAD_BEEF);
    check("t2_be", be_a[1], 4'hF);
    check("t2_write_held", {wr_a[1], wr_a[2], wr_a[3], wr_a[4]}, 4'b1110);
    check("t2_no_read", rd_a[1] | rd_a[2] | rd_a[3], 0);
    check("t2_ddone", {dd_a[3], dd_a[4], dd_a[5]}, 3'b010);
    check("t2_stall", st_a[4], 2);
    check("t2_nodouble", wr_a[5], 0);

    // ---------------- simultaneous requests
    first_is_d = !RR;
    fa = first_is_d ? 32'h1000_8004 : 32'h0040_0010;
    sa = first_is_d ? 32'h0040_0010 : 32'h1000_8004;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0040_0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_8006; d_be = 4'h3;
    bus.readdata = 32'h0BAD_F00D;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      samp(k);
      bus.readdata = (k == 2) ? mem(fa) : (k == 5) ? mem(sa) : 32'h0BAD_F00D;
      if (k == 4) begin
        if (first_is_d) d_req = 1'b0; else i_req = 1'b0;
      end
      if (k == 7) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    dcyc = first_is_d ? 3 : 6;
    check("t3_first_addr", ad_a[1], fa);
    check("t3_second_addr", ad_a[4], sa);
    check("t3_reads", {rd_a[1], rd_a[2], rd_a[3], rd_a[4]}, 4'b1001);
    check("t3_first_done", first_is_d ? dd_a[3] : id_a[3], 1);
    check("t3_second_early", first_is_d ? id_a[3] : dd_a[3], 0);
    check("t3_second_done", first_is_d ? id_a[6] : dd_a[6], 1);
    check("t3_first_once", first_is_d ? dd_a[6] : id_a[6], 0);
    check("t3_d_rdata", dr_a[7], mem(32'h1000_8004));
    check("t3_i_rdata", ir_a[7], mem(32'h0040_0010));
    check("t3_irdata_at_ddone", ir_a[dcyc], first_is_d ? 32'h2402_0005 : mem(32'h0040_0010));
    check("t3_d_be", be_a[first_is_d ? 1 : 4], 4'h3);

    // ---------------- reset during a stalled read
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_2000; bus.waitrequest = 1'b1;
    @(negedge clk);
    check("t4_read_pre", bus.read, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_read_drop", bus.read, 0);
    check("t4_write_drop", bus.write, 0);
    check("t4_busy_drop", busy, 0);
    check("t4_stall_clr", stall_cnt, 0);
    check("t4_rdata_clr", {i_rdata, d_rdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; i_req = 1'b0; bus.waitrequest = 1'b0;
    any_done = 1'b0; any_bus = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      any_done |= i_done | d_done;
      any_bus  |= bus.read | bus.write;
    end
    check("t4_no_done", any_done, 0);
    check("t4_no_bus", any_bus, 0);
    i_req = 1'b1; i_addr = 32'h0000_3008; bus.readdata = mem(32'h0000_3008);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      samp(k);
      if (k == 4) i_req = 1'b0;
    end
    check("t4_fresh_addr", ad_a[1], 32'h0000_3008);
    check("t4_fresh_done", {id_a[2], id_a[3]}, 2'b01);
    check("t4_fresh_rdata", ir_a[3], mem(32'h0000_3008));

    // ---------------- stall counter saturation
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_4000; bus.readdata = mem(32'h0000_4000);
    bus.waitrequest = 1'b1;
    for (int k = 1; k <= 32'hFFFF + 9; k++) begin
      @(negedge clk);
      if (k == 101) check("t5_stall_100", stall_cnt, 100);
      if (k == 32'h10000) check("t5_stall_max", stall_cnt, 16'hFFFF);
      if (k == 32'hFFFF + 6) begin
        check("t5_stall_sat", stall_cnt, 16'hFFFF);
        check("t5_read_held", bus.read, 1);
        bus.waitrequest = 1'b0;
      end
      if (k == 32'hFFFF + 8) begin
        check("t5_done", i_done, 1);
        check("t5_rdata", i_rdata, mem(32'h0000_4000));
        check("t5_stall_end", stall_cnt, 16'hFFFF);
      end
      if (k == 32'hFFFF + 9) i_req = 1'b0;
    end

    // ---------------- randomized traffic
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_i_at = -1; exp_d_at = -1; resp_at = -1;
    pend_i = 0; pend_d = 0; drop_i = 0; drop_d = 0; elig_i = 0; elig_d = 0;
    prev_bus = 0; last_d_m = 0; own_d_m = 0; txn_rd = 0; stall_left = 0;
    txn_addr = '0; ir_m = '0; dr_m = '0; st_m = '0; age_i = 0; age_d = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rd = bus.read; wr = bus.write; id = i_done; dd = d_done;
      check("r_excl", rd & wr, 0);
      check("r_busy", busy, rd | wr | (c == resp_at));
      check("r_stall", stall_cnt, st_m);
      check("r_idone", id, c == exp_i_at);
      check("r_ddone", dd, c == exp_d_at);
      check("r_irdata", i_rdata, ir_m);
      check("r_drdata", d_rdata, dr_m);
      if ((rd | wr) && !prev_bus) begin
        check("r_grant_req", elig_i | elig_d, 1);
        own_d_m  = (elig_i && elig_d) ? (RR ? !last_d_m : 1'b1) : elig_d;
        last_d_m = own_d_m;
        txn_rd   = rd;
        if (own_d_m) begin
          txn_addr = d_addr & ~32'h3;
          check("r_d_we", wr, d_we);
          check("r_d_be", bus.byteenable, d_be);
          if (d_we) check("r_d_wdata", bus.writedata, d_wdata);
        end else begin
          txn_addr = i_addr & ~32'h3;
          check("r_i_read", rd, 1);
          check("r_i_be", bus.byteenable, 4'hF);
        end
        stall_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      end
      if (rd | wr) check("r_addr", bus.address, txn_addr);

      // slave response
      if (rd | wr) begin
        if (stall_left > 0) begin
          bus.waitrequest = 1'b1;
          stall_left--;
          if (st_m != 16'hFFFF) st_m++;
        end else begin
          bus.waitrequest = 1'b0;
          if (txn_rd) begin
            resp_at = c + 1;
            if (own_d_m) exp_d_at = c + 2; else exp_i_at = c + 2;
          end else begin
            exp_d_at = c + 1;
          end
        end
      end else begin
        bus.waitrequest = 1'($urandom_range(0, 1));
      end
      if (c == resp_at) begin
        bus.readdata = mem(txn_addr);
        if (own_d_m) dr_m = mem(txn_addr); else ir_m = mem(txn_addr);
      end else begin
        bus.readdata = $urandom;
      end

      // requesters: hold until done, release one cycle later
      if (drop_i) begin
        i_req = 1'b0; pend_i = 0; drop_i = 0;
      end else if (pend_i) begin
        if (id) drop_i = 1;
        else begin
          age_i++;
          if (age_i > 60) begin
            check("r_i_timeout", age_i, 60);
            i_req = 1'b0; pend_i = 0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        pend_i = 1; age_i = 0; i_req = 1'b1; i_addr = $urandom;
      end
      if (drop_d) begin
        d_req = 1'b0; pend_d = 0; drop_d = 0;
      end else if (pend_d) begin
        if (dd) drop_d = 1;
        else begin
          age_d++;
          if (age_d > 60) begin
            check("r_d_timeout", age_d, 60);
            d_req = 1'b0; pend_d = 0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        pend_d = 1; age_d = 0; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end
      elig_i   = i_req & ~id;
      elig_d   = d_req & ~dd;
      prev_bus = rd | wr;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
